// File: rtl/dr_load_sequencer.sv
// Sequences 1-4 byte loads from a synchronous-read byte memory into the 32-bit DataRegister.
// Optional one-entry request buffer with QFull output: define DRSEQ_QUEUE_EN.
module dr_load_sequencer #(
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  Start,
  input  logic [ADDR_WIDTH-1:0] Address,
  input  logic [1:0]            ByteCount,
  input  logic                  SignExt,
  input  logic                  LittleEnd,
  output logic [ADDR_WIDTH-1:0] MemAddr,
  output logic                  MemRead,
  output logic                  DR_E,
  output logic [1:0]            DR_FunSel,
  output logic                  Busy,
`ifdef DRSEQ_QUEUE_EN
  output logic                  QFull,
`endif
  output logic                  Done
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_e;

  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic [1:0]            rem_q;
  logic                  le_q, sign_q;
  logic                  first_issue_q, wr_first_q;
  logic [1:0]            funsel_q;
  logic                  done_q;

  logic                  launch, from_buf;
  logic [ADDR_WIDTH-1:0] l_addr;
  logic [1:0]            l_cnt;
  logic                  l_sign, l_le;

`ifdef DRSEQ_QUEUE_EN
  logic                  buf_valid_q;
  logic [ADDR_WIDTH-1:0] buf_addr_q;
  logic [1:0]            buf_cnt_q;
  logic                  buf_sign_q, buf_le_q;
`endif

  // NOTE: every signal assigned in always_comb gets a default first, so no latch can be inferred.
  always_comb begin
    from_buf = 1'b0;
    launch   = Start && (state_q == S_IDLE || state_q == S_DONE);
    l_addr   = Address;
    l_cnt    = ByteCount;
    l_sign   = SignExt;
    l_le     = LittleEnd;
`ifdef DRSEQ_QUEUE_EN
    // A buffered request, or a fresh Start, chains straight out of DRAIN with no gap.
    if (state_q == S_DRAIN) begin
      from_buf = buf_valid_q;
      launch   = buf_valid_q || Start;
    end
    if (from_buf) begin
      l_addr = buf_addr_q;
      l_cnt  = buf_cnt_q;
      l_sign = buf_sign_q;
      l_le   = buf_le_q;
    end
`endif
  end

  // NOTE: sequential state uses non-blocking assignments and clears asynchronously on Reset low.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (launch) state_d = S_ISSUE;
      S_ISSUE: if (rem_q == 2'd0) state_d = S_DRAIN;
      S_DRAIN: state_d = launch ? S_ISSUE : S_DONE;
      S_DONE:  state_d = launch ? S_ISSUE : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    MemAddr   = mem_addr_q;
    MemRead   = (state_q == S_ISSUE);
    DR_E      = (state_q == S_ISSUE && !first_issue_q) || (state_q == S_DRAIN);
    Busy      = (state_q == S_ISSUE) || (state_q == S_DRAIN);
    Done      = done_q;
    DR_FunSel = funsel_q;
    // The first byte carries the extension; later bytes shift in underneath it.
    if (DR_E) DR_FunSel = wr_first_q ? {1'b0, ~sign_q} : 2'b10;
`ifdef DRSEQ_QUEUE_EN
    Busy      = Busy || buf_valid_q;
    QFull     = buf_valid_q;
`endif
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      mem_addr_q    <= '0;
      rem_q         <= 2'd0;
      le_q          <= 1'b0;
      sign_q        <= 1'b0;
      first_issue_q <= 1'b0;
      wr_first_q    <= 1'b0;
      funsel_q      <= 2'b00;
      done_q        <= 1'b0;
    end else begin
      funsel_q   <= DR_FunSel;
      done_q     <= (state_q == S_DRAIN);
      wr_first_q <= (state_q == S_ISSUE) && first_issue_q;
      if (launch) begin
        // Little-endian fetches the most significant (highest-addressed) byte first.
        mem_addr_q    <= l_le ? l_addr + ADDR_WIDTH'(l_cnt) : l_addr;
        rem_q         <= l_cnt;
        le_q          <= l_le;
        sign_q        <= l_sign;
        first_issue_q <= 1'b1;
      end else if (state_q == S_ISSUE) begin
        first_issue_q <= 1'b0;
        if (rem_q != 2'd0) begin
          rem_q      <= rem_q - 2'd1;
          mem_addr_q <= le_q ? mem_addr_q - ADDR_ONE : mem_addr_q + ADDR_ONE;
        end
      end
    end
  end

`ifdef DRSEQ_QUEUE_EN
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      buf_valid_q <= 1'b0;
      buf_addr_q  <= '0;
      buf_cnt_q   <= 2'd0;
      buf_sign_q  <= 1'b0;
      buf_le_q    <= 1'b0;
    end else if (state_q == S_ISSUE && Start && !buf_valid_q) begin
      buf_valid_q <= 1'b1;
      buf_addr_q  <= Address;
      buf_cnt_q   <= ByteCount;
      buf_sign_q  <= SignExt;
      buf_le_q    <= LittleEnd;
    end else if (from_buf) begin
      buf_valid_q <= 1'b0;
    end
  end
`endif

endmodule
